dm: RTL and testbench
=====================

Name: dm

Overview:
- Word-addressed, single-port data memory for the RISC datapath load/store stage.
- Synchronous write: one 32-bit word per clock when write enable is high.
- Combinational (asynchronous) read: the addressed word is always visible on data_out.
- Asynchronous active-low reset clears the whole array.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 2..1024.
- AW, $clog2(DEPTH), index width; derived, must not be overridden.

Ports:
- clk  input  1  clock; writes take effect on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- add  input  32  word address (not byte address); consecutive words at add, add+1.
- data_in  input  32  write data.
- wen  input  1  write enable, active high, sampled on rising clk.
- data_out  output  32  read data for the current add.

Behaviour:
- Storage: DEPTH x 32-bit registers mem[0..DEPTH-1].
- Reset: rst_n low asynchronously forces every mem word to 32'h0; data_out reads 0 while reset is held. Clears on assertion, independent of clk. Writes are ignored while rst_n is low.
- Reset deassertion: the first write can occur on the first rising edge with rst_n high.
- Index: idx = add[AW-1:0]. Without the optional feature, upper address bits are ignored, so addresses wrap modulo DEPTH (add = DEPTH+2 aliases word 2).
- Write: on a rising clk with rst_n=1 and wen=1, mem[idx] <= data_in. With wen=0, no state changes.
- Read: data_out = mem[idx], purely combinational. Zero-cycle latency from add to data_out, settled within the same cycle.
- Read-during-write, same address: data_out shows the old contents until the rising edge, then the new value in the same timestep as the update. No write-through bypass.
- wen, add and data_in need to be stable only around the rising edge. Changes between edges have no effect on stored state.
- X/Z on wen during an edge is treated as no write.
- Back-to-back writes on consecutive cycles to any addresses are supported; the last write to an address wins.
- No handshake, no busy state, no FSM.

Optional Feature:
- Macro: DM_RANGE_CHECK_EN.
- Defined:
  - Adds output port addr_err (1 bit), asserted combinationally when add >= DEPTH (any of add[31:AW] nonzero).
  - When addr_err=1, writes are suppressed and data_out is forced to 32'h0.
  - addr_err is 0 during reset.
- Undefined:
  - No addr_err port.
  - Out-of-range addresses wrap on the low AW bits as described above.

Test Plan:
- Reset: load nonzero words, pulse rst_n low mid-cycle (not on a clock edge) -> data_out=0 immediately; addresses 0, 2 and DEPTH-1 all read 0 after release.
- Basic write/read: rst_n=1, add=2, data_in=12, wen=1, one rising edge -> data_out=12 with add=2; add=3 reads 0.
- Write-disable: add=3, data_in=13, wen=0, rising edge -> add=3 still reads 0; add=2 still reads 12.
- Interleaved sequence, wen toggling every cycle while add and data_in increment from (2,12) -> only the cycles with wen=1 store data (e.g. mem[2]=12, mem[4]=14); the skipped addresses read 0.
- Read-during-write: mem[5]=0xA5A5A5A5, then add=5, data_in=0x5A5A5A5A, wen=1 -> data_out=0xA5A5A5A5 before the edge and 0x5A5A5A5A after it.
- Boundary: with DEPTH=64, write 0xDEADBEEF at add=63, then read add=63 -> 0xDEADBEEF. Then write 0x1 at add=66:
  - Without the macro: reading add=2 returns 0x1.
  - With DM_RANGE_CHECK_EN: addr_err=1, data_out=0, and mem[2] is unchanged.

Source files
------------

// File: rtl/dm.sv
// rtl/dm.sv - word-addressed single-port data memory, sync write / async read.
// Optional DM_RANGE_CHECK_EN adds addr_err and blocks out-of-range accesses.
module dm #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] add,
  input  logic [31:0] data_in,
  input  logic        wen,
`ifdef DM_RANGE_CHECK_EN
  output logic        addr_err,
`endif
  output logic [31:0] data_out
);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          wr_ok;

  assign idx          = add[AW-1:0];
  assign out_of_range = |add[31:AW];

`ifdef DM_RANGE_CHECK_EN
  assign addr_err = rst_n & out_of_range;
  assign wr_ok    = wen & ~out_of_range;
  assign data_out = out_of_range ? 32'h0 : mem_q[idx];
`else
  // Upper address bits alias onto the low AW bits in this build.
  logic unused_hi_bits;
  assign unused_hi_bits = out_of_range;
  assign wr_ok          = wen;
  assign data_out       = mem_q[idx];
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_ok) begin
      mem_d[idx] = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dm.sv
// tb/tb_dm.sv - scoreboard bench for dm; expected words queued by stimulus, checked at negedge.
module tb_dm;

  logic        clk;
  logic        rst_n;
  logic [31:0] add;
  logic [31:0] data_in;
  logic        wen;
  logic [31:0] data_out;
`ifdef DM_RANGE_CHECK_EN
  logic        addr_err;
`endif

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic        exp_err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  dm #(.DEPTH(64)) u_dm (
    .clk      (clk),
    .rst_n    (rst_n),
    .add      (add),
    .data_in  (data_in),
    .wen      (wen),
`ifdef DM_RANGE_CHECK_EN
    .addr_err (addr_err),
`endif
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (data_out !== e.exp) begin
        n_fail++;
        $display("FAIL %s: data_out=%h expected=%h", e.name, data_out, e.exp);
      end
`ifdef DM_RANGE_CHECK_EN
      n_tests++;
      if (addr_err !== e.exp_err) begin
        n_fail++;
        $display("FAIL %s_err: addr_err=%b expected=%b", e.name, addr_err, e.exp_err);
      end
`endif
    end
  end

  task automatic push(input string name, input logic [31:0] exp, input logic exp_err);
    exp_t e;
    e.name    = name;
    e.exp     = exp;
    e.exp_err = exp_err;
    sb.push_back(e);
  endtask

  // Drive inputs just after a rising edge; expectation is data_out before the next edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [31:0] exp, input string name);
    @(posedge clk);
    #1;
    add     = a;
    data_in = d;
    wen     = w;
    push(name, exp, 1'b0);
  endtask

  initial begin
    int budget;
    rst_n   = 1'b0;
    add     = 32'h0;
    data_in = 32'h0;
    wen     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    step(0, 0, 0, 32'h0, "reset_rd0");
    step(0, 32'h11, 1, 32'h0, "load0_pre");
    step(2, 32'h22, 1, 32'h0, "load2_pre");
    step(63, 32'h33, 1, 32'h0, "load63_pre");
    step(0, 0, 0, 32'h11, "load0");

    // Asynchronous reset pulse away from any clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push("rst_async", 32'h0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(0, 0, 0, 32'h0, "rst_rd0");
    step(2, 0, 0, 32'h0, "rst_rd2");
    step(63, 0, 0, 32'h0, "rst_rd63");

    step(2, 12, 1, 32'h0, "basic_pre");
    step(2, 0, 0, 32'd12, "basic2");
    step(3, 0, 0, 32'h0, "basic3");

    step(3, 13, 0, 32'h0, "wdis_pre");
    step(3, 0, 0, 32'h0, "wdis3");
    step(2, 0, 0, 32'd12, "wdis2");

    step(2, 12, 1, 32'd12, "intl_2");
    step(3, 13, 0, 32'h0, "intl_3");
    step(4, 14, 1, 32'h0, "intl_4");
    step(5, 15, 0, 32'h0, "intl_5");
    step(6, 16, 1, 32'h0, "intl_6");
    step(7, 17, 0, 32'h0, "intl_7");
    step(2, 0, 0, 32'd12, "intl_rd2");
    step(3, 0, 0, 32'h0, "intl_rd3");
    step(4, 0, 0, 32'd14, "intl_rd4");
    step(5, 0, 0, 32'h0, "intl_rd5");
    step(6, 0, 0, 32'd16, "intl_rd6");
    step(7, 0, 0, 32'h0, "intl_rd7");

    step(5, 32'hA5A5A5A5, 1, 32'h0, "rdw_load");
    step(5, 32'h5A5A5A5A, 1, 32'hA5A5A5A5, "rdw_before");
    step(5, 0, 0, 32'h5A5A5A5A, "rdw_after");

    step(63, 32'hDEADBEEF, 1, 32'h0, "top_pre");
    step(63, 0, 0, 32'hDEADBEEF, "top63");

`ifdef DM_RANGE_CHECK_EN
    @(posedge clk);
    #1;
    add     = 32'd66;
    data_in = 32'h1;
    wen     = 1'b1;
    push("oor_66", 32'h0, 1'b1);
    step(2, 0, 0, 32'd12, "oor_rd2");
`else
    step(66, 32'h1, 1, 32'd12, "wrap_66");
    step(2, 0, 0, 32'h1, "wrap_rd2");
`endif
    step(63, 0, 0, 32'hDEADBEEF, "last63");
    step(4, 0, 0, 32'd14, "last4");

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
